mux4_reg: RTL and testbench

- Four-input, one-hot-free 4:1 selector: `sel` picks one of `a`, `b`, `c`, `d` and drives it to `out`.
- Output is registered: one clock of latency and a `valid` qualifier.
- Used as the per-bit / per-lane select stage inside wider bus multiplexers (e.g. 8-bit 4-way bus mux built from WIDTH=1 instances, or a single WIDTH=8 instance).

---
 rtl/mux4_pkg.sv | 11 +
 rtl/mux4_comb_core.sv | 30 +++
 rtl/mux4_reg.sv | 61 ++++++
 tb/tb_mux4_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mux4_pkg.sv
// rtl/mux4_pkg.sv - select codes and select type shared by the mux4 blocks
package mux4_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux4_comb_core.sv
// rtl/mux4_comb_core.sv - purely combinational WIDTH-bit 4:1 select
//   a, b, c, d : data inputs for sel = 00, 01, 10, 11
//   sel        : select code
//   mux_q      : selected data, zero latency
module mux4_comb_core
    import mux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  sel_t             sel,
    output logic [WIDTH-1:0] mux_q
);

    // A case on a known sel copies only the chosen input, so X on an
    // unselected input never reaches mux_q.
    always_comb begin
        mux_q = d;
        case (sel)
            SEL_A:   mux_q = a;
            SEL_B:   mux_q = b;
            SEL_C:   mux_q = c;
            default: mux_q = d;
        endcase
    end

endmodule

// File: rtl/mux4_reg.sv
// rtl/mux4_reg.sv - registered 4:1 selector with output valid qualifier
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears out and out_valid
//   a..d      : data inputs for sel = 00, 01, 10, 11
//   sel       : select code
//   in_valid  : qualifies a..d/sel this cycle
//   out       : registered selected data, holds when in_valid is low
//   out_valid : high the cycle after a qualified sample
//   out_comb  : bare mux path, present only with MUX4_REG_COMB_OUT_EN defined
module mux4_reg
    import mux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  sel_t             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
`ifdef MUX4_REG_COMB_OUT_EN
    ,
    output logic [WIDTH-1:0] out_comb
`endif
);

    logic [WIDTH-1:0] mux_q;

    mux4_comb_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .sel   (sel),
        .mux_q (mux_q)
    );

    // Data only loads on a qualified sample; valid tracks in_valid every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= mux_q;
            end
        end
    end

`ifdef MUX4_REG_COMB_OUT_EN
    assign out_comb = mux_q;
`endif

endmodule

// File: tb/tb_mux4_reg.sv
// tb/tb_mux4_reg.sv - directed self-checking bench for mux4_reg (WIDTH=8 and WIDTH=1)
module tb_mux4_reg;

    logic       clk;
    logic       rst_n;
    logic [7:0] a, b, c, d;
    logic [1:0] sel;
    logic       in_valid;
    logic [7:0] out;
    logic       out_valid;

    logic       a1, b1, c1, d1;
    logic [1:0] sel1;
    logic       in_valid1;
    logic       out1;
    logic       out_valid1;

`ifdef MUX4_REG_COMB_OUT_EN
    logic [7:0] out_comb;
    logic       out_comb1;
`endif

    int checks = 0;
    int errors = 0;

    mux4_reg #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
`ifdef MUX4_REG_COMB_OUT_EN
        ,
        .out_comb  (out_comb)
`endif
    );

    mux4_reg #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .d         (d1),
        .sel       (sel1),
        .in_valid  (in_valid1),
        .out       (out1),
        .out_valid (out_valid1)
`ifdef MUX4_REG_COMB_OUT_EN
        ,
        .out_comb  (out_comb1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        a         = 8'h81;
        b         = 8'hC3;
        c         = 8'hE7;
        d         = 8'hF1;
        sel       = 2'b00;
        in_valid  = 1'b0;
        a1        = 1'b1;
        b1        = 1'b0;
        c1        = 1'b1;
        d1        = 1'b0;
        sel1      = 2'b00;
        in_valid1 = 1'b0;
        #1;
        chk("reset_out", 64'(out), 64'h00);
        chk("reset_valid", 64'(out_valid), 64'h0);
        chk("reset_out_w1", 64'(out1), 64'h0);

        // Hold reset across an edge with a qualified sample pending.
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_hold_out", 64'(out), 64'h00);
        chk("reset_hold_valid", 64'(out_valid), 64'h0);

        // Release between edges (t=12ish).
        #5;
        rst_n = 1'b1;

        sel = 2'b00; step(); chk("sel00_out", 64'(out), 64'h81); chk("sel00_valid", 64'(out_valid), 64'h1);
        sel = 2'b01; step(); chk("sel01_out", 64'(out), 64'hC3); chk("sel01_valid", 64'(out_valid), 64'h1);
        sel = 2'b10; step(); chk("sel10_out", 64'(out), 64'hE7); chk("sel10_valid", 64'(out_valid), 64'h1);
        sel = 2'b11; step(); chk("sel11_out", 64'(out), 64'hF1); chk("sel11_valid", 64'(out_valid), 64'h1);

        sel = 2'b10; step(); chk("hold_sel10_out", 64'(out), 64'hE7);

        in_valid = 1'b0;
        c        = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_out", 64'(out), 64'hE7);
            chk("idle_valid", 64'(out_valid), 64'h0);
        end
        c = 8'hE7;

        in_valid = 1'b1;
        sel      = 2'b11;
        step();
        chk("pre_rst_out", 64'(out), 64'hF1);
        chk("pre_rst_valid", 64'(out_valid), 64'h1);

        // Asynchronous reset mid-cycle: outputs clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", 64'(out), 64'h00);
        chk("async_rst_valid", 64'(out_valid), 64'h0);

        sel = 2'b01;
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_out", 64'(out), 64'hC3);
        chk("post_rst_valid", 64'(out_valid), 64'h1);

        // Reset mid-stream: in-flight sample discarded, valid stays low.
        sel = 2'b10;
        #2;
        rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        chk("midstream_out", 64'(out), 64'h00);
        chk("midstream_valid", 64'(out_valid), 64'h0);

        // X on unselected input must not reach out.
        in_valid = 1'b1;
        sel      = 2'b00;
        b        = 8'hxx;
        step();
        chk("xunsel_out", 64'(out), 64'h81);
        b = 8'hC3;

        // Rapid sel changes on WIDTH=8 in reverse order.
        sel = 2'b11; step(); chk("rev11_out", 64'(out), 64'hF1);
        sel = 2'b00; step(); chk("rev00_out", 64'(out), 64'h81);

        // WIDTH=1 sweep: 1, 0, 1, 0.
        in_valid1 = 1'b1;
        sel1 = 2'b00; step(); chk("w1_sel00", 64'(out1), 64'h1);
        sel1 = 2'b01; step(); chk("w1_sel01", 64'(out1), 64'h0);
        sel1 = 2'b10; step(); chk("w1_sel10", 64'(out1), 64'h1);
        sel1 = 2'b11; step(); chk("w1_sel11", 64'(out1), 64'h0);
        chk("w1_valid", 64'(out_valid1), 64'h1);
        in_valid1 = 1'b0;
        step();
        chk("w1_idle_valid", 64'(out_valid1), 64'h0);
        chk("w1_idle_out", 64'(out1), 64'h0);

`ifdef MUX4_REG_COMB_OUT_EN
        #2;
        sel = 2'b11;
        #1;
        chk("comb_sel11", 64'(out_comb), 64'hF1);
        sel = 2'b01;
        #1;
        chk("comb_sel01", 64'(out_comb), 64'hC3);
        rst_n = 1'b0;
        sel   = 2'b11;
        #1;
        chk("comb_in_rst", 64'(out_comb), 64'hF1);
        chk("comb_rst_out", 64'(out), 64'h00);
        rst_n = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
